tmds_serializer: RTL

- Downstream consumer of the /5 bit-clock divider in the DVI output path.
- Runs on the fast TMDS bit clock: 5 cycles per pixel, 2 bits per cycle via DDR output cells.
- Each pixel period it accepts one 10-bit TMDS symbol per channel (3 channels: B, G, R) through a valid/ready handshake.
- Shifts each symbol out LSB-first as rise/fall bit pairs for the IO DDR primitives.
- On an upstream miss it substitutes a filler symbol and flags underflow.

---
 rtl/tmds_serializer_pkg.sv | 23 ++
 rtl/tmds_shift10.sv | 27 ++
 rtl/tmds_serializer.sv | 62 ++++++
 3 files changed

// File: rtl/tmds_serializer_pkg.sv
// Shared TMDS constants: symbol width, pixel phases, control symbols and channel indices.
package tmds_serializer_pkg;

   localparam int TMDS_SYM_W = 10;
   localparam int PHASES     = 5;

   localparam logic [TMDS_SYM_W-1:0] CTRL_00 = 10'b1101010100;
   localparam logic [TMDS_SYM_W-1:0] CTRL_01 = 10'b0010101011;
   localparam logic [TMDS_SYM_W-1:0] CTRL_10 = 10'b0101010100;
   localparam logic [TMDS_SYM_W-1:0] CTRL_11 = 10'b1010101011;

   localparam int CH_B = 0;
   localparam int CH_G = 1;
   localparam int CH_R = 2;

   localparam logic [2:0] LAST_PHASE = 3'(PHASES - 1);

   // Mod-5 successor of the bit-pair phase.
   function automatic logic [2:0] phase_next(input logic [2:0] p);
      return (p == LAST_PHASE) ? 3'd0 : p + 3'd1;
   endfunction

endpackage

// File: rtl/tmds_shift10.sv
// One TMDS channel: 10-bit symbol register that loads a symbol and then emits two bits per clock.
module tmds_shift10
   import tmds_serializer_pkg::*;
(
   input  logic                  clki,
   input  logic                  rst,
   input  logic                  load,
   input  logic [TMDS_SYM_W-1:0] din,
   output logic                  rise,
   output logic                  fall
);

   logic [TMDS_SYM_W-1:0] sr;

   always_ff @(posedge clki or posedge rst) begin
      if (rst)
         sr <= '0;
      else if (load)
         sr <= din;
      else
         sr <= {2'b00, sr[TMDS_SYM_W-1:2]};
   end

   assign rise = sr[0];
   assign fall = sr[1];

endmodule

// File: rtl/tmds_serializer.sv
// TMDS 10:1 serializer on the bit clock: one symbol set per 5-cycle pixel, LSB-first DDR bit pairs.
module tmds_serializer
   import tmds_serializer_pkg::*;
#(
   parameter int                    NCH      = 3,
   parameter logic [TMDS_SYM_W-1:0] FILL_SYM = CTRL_00
)
(
   input  logic                      clki,
   input  logic                      rst,
   input  logic                      align,
   input  logic [TMDS_SYM_W*NCH-1:0] sym_data,
   input  logic                      sym_valid,
   output logic                      sym_ready,
   output logic [NCH-1:0]            ddr_rise,
   output logic [NCH-1:0]            ddr_fall,
   output logic [2:0]                phase,
   output logic                      underflow,
   input  logic                      underflow_clr
);

   logic load;

   // An align request steals the load slot, so the shifters keep draining instead.
   assign sym_ready = (phase == LAST_PHASE) && !align;
   assign load      = sym_ready;

   always_ff @(posedge clki or posedge rst) begin
      if (rst)
         phase <= 3'd0;
      else if (align)
         phase <= 3'd0;
      else
         phase <= phase_next(phase);
   end

   // Set takes priority over clear so a miss on the clearing edge is not lost.
   always_ff @(posedge clki or posedge rst) begin
      if (rst)
         underflow <= 1'b0;
      else if (load && !sym_valid)
         underflow <= 1'b1;
      else if (underflow_clr)
         underflow <= 1'b0;
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [TMDS_SYM_W-1:0] din;

      assign din = sym_valid ? sym_data[TMDS_SYM_W*k +: TMDS_SYM_W] : FILL_SYM;

      tmds_shift10 u_shift (
         .clki (clki),
         .rst  (rst),
         .load (load),
         .din  (din),
         .rise (ddr_rise[k]),
         .fall (ddr_fall[k])
      );
   end

endmodule
